// File: rtl/morse_seq_module.sv
// Programmable Morse sequencer: plays a DEPTH-entry symbol buffer on pin_out,
// timed in units of UNIT_CNT clocks, with start/busy/done handshake and loop mode.
module morse_seq_module #(
  parameter int UNIT_CNT = 5000000,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          pin_out
);

  // state | meaning
  // IDLE  | waiting for a valid start
  // ON    | tone on for the current symbol's on-units
  // OFF   | tone off for the current symbol's off-units
  // END   | one-cycle done pulse, then loop to symbol 0 or return to IDLE
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_END} state_t;

  localparam int CW = $clog2(UNIT_CNT * 7);
  localparam logic [CW-1:0] LIM_1 = CW'(UNIT_CNT - 1);
  localparam logic [CW-1:0] LIM_2 = CW'(2 * UNIT_CNT - 1);
  localparam logic [CW-1:0] LIM_3 = CW'(3 * UNIT_CNT - 1);
  localparam logic [CW-1:0] LIM_6 = CW'(6 * UNIT_CNT - 1);
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);

  logic [1:0]    mem [DEPTH];
  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx, idx_inc;
  logic [CW-1:0] cnt, cnt_nx, on_lim, off_lim;
  logic [AW:0]   len_q, len_nx;
  logic [1:0]    sym, sym_next, sym_first;
  logic          start_ok, more;

  always_ff @(posedge CLK) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  assign idx_inc   = idx + AW'(1);
  assign sym       = mem[idx];
  assign sym_next  = mem[idx_inc];
  assign sym_first = mem[0];
  assign start_ok  = start && (len != '0) && (len <= LEN_MAX);
  assign more      = ({1'b0, idx} + LEN_ONE) < len_q;

  always_comb begin
    on_lim = LIM_1;
    if (sym == 2'b01) on_lim = LIM_3;
    case (sym)
      2'b10:   off_lim = LIM_2;
      2'b11:   off_lim = LIM_6;
      default: off_lim = LIM_1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      len_q <= len_nx;
    end
  end

  // Gap symbols (code bit 1 set) have no on-phase and enter OFF directly.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + CW'(1);
    len_nx   = len_q;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start_ok) begin
          len_nx   = len;
          idx_nx   = '0;
          state_nx = sym_first[1] ? S_OFF : S_ON;
        end
      end
      S_ON: begin
        if (cnt == on_lim) begin
          cnt_nx   = '0;
          state_nx = S_OFF;
        end
      end
      S_OFF: begin
        if (cnt == off_lim) begin
          cnt_nx = '0;
          if (more) begin
            idx_nx   = idx_inc;
            state_nx = sym_next[1] ? S_OFF : S_ON;
          end else begin
            state_nx = S_END;
          end
        end
      end
      S_END: begin
        cnt_nx = '0;
        if (loop_en) begin
          idx_nx   = '0;
          state_nx = sym_first[1] ? S_OFF : S_ON;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_END);
  assign pin_out = (state == S_ON);

endmodule

// File: tb/tb_morse_seq_module.sv
// Bench for morse_seq_module: expected pin/busy/done per cycle are expanded
// from the symbol list with the Morse unit rules, then compared every cycle.
module tb_morse_seq_module;
  localparam int UNIT_CNT = 4;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int ON_U[4]  = '{1, 3, 0, 0};
  localparam int OFF_U[4] = '{1, 1, 2, 6};

  logic          CLK = 1'b0, RSTn = 1'b0;
  logic          wr_en = 1'b0, loop_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_data = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, pin_out;

  int checks = 0, errors = 0;
  int fd, ld, total;
  bit saw_done;
  logic [1:0] msg [DEPTH];

  morse_seq_module #(.UNIT_CNT(UNIT_CNT), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop_en(loop_en), .start(start), .abort(abort),
    .busy(busy), .done(done), .pin_out(pin_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sos();
    logic [1:0] sos [11];
    sos = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 11; i++) msg[i] = sos[i];
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = msg[i];
    end
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // Start at cycle 0; cycle 1 is the first playing cycle. Optionally scribbles
  // writes, start pulses and len changes while busy, all of which must be ignored.
  task automatic play(input int n, input int passes, input bit scribble,
                      output int first_done, output int last_done);
    bit exp_pin[$];
    int cyc;
    for (int i = 0; i < n; i++) begin
      repeat (ON_U[msg[i]] * UNIT_CNT) exp_pin.push_back(1'b1);
      repeat (OFF_U[msg[i]] * UNIT_CNT) exp_pin.push_back(1'b0);
    end
    first_done = -1; last_done = -1;
    @(negedge CLK);
    len = n[AW:0]; loop_en = (passes > 1); start = 1'b1;
    @(negedge CLK);
    start = 1'b0; cyc = 1;
    for (int p = 1; p <= passes; p++) begin
      loop_en = (p < passes);
      foreach (exp_pin[k]) begin
        check("pin", pin_out, exp_pin[k]);
        check("busy", busy, 1);
        check("done", done, 0);
        if (scribble) begin
          wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = 2'($urandom);
          start = 1'b1; len = (AW+1)'(1);
        end
        @(negedge CLK); cyc++;
      end
      wr_en = 1'b0; start = 1'b0;
      check("end_done", done, 1);
      check("end_busy", busy, 1);
      check("end_pin", pin_out, 0);
      if (first_done < 0) first_done = cyc;
      last_done = cyc;
      @(negedge CLK); cyc++;
    end
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_pin", pin_out, 0);
  endtask

  task automatic bad_start(input int l);
    @(negedge CLK);
    len = l[AW:0]; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) begin
      check("badlen_busy", busy, 0);
      check("badlen_pin", pin_out, 0);
      @(negedge CLK);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pin", pin_out, 0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_busy", busy, 0);

    set_sos(); load(11);
    play(11, 1, 1'b0, fd, ld);
    check("sos_done_cycle", ld, 113);

    play(11, 2, 1'b0, fd, ld);
    check("loop_done1", fd, 113);
    check("loop_done2", ld, 226);

    // abort during the first dash (cycles 33-44)
    @(negedge CLK);
    len = 5'd11; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (34) @(negedge CLK);
    check("abort_pre_pin", pin_out, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_pin", pin_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", saw_done, 0);
    abort = 1'b1; start = 1'b1; len = 5'd11;
    @(negedge CLK);
    abort = 1'b0; start = 1'b0;
    check("abort_over_start", busy, 0);
    play(11, 1, 1'b0, fd, ld);
    check("replay_after_abort", ld, 113);

    bad_start(0);
    bad_start(17);

    play(11, 1, 1'b1, fd, ld);
    play(11, 1, 1'b0, fd, ld);
    check("replay_after_scribble", ld, 113);

    msg[0] = 2'd3; load(1);
    play(1, 1, 1'b0, fd, ld);
    check("wgap_done_cycle", ld, 25);

    for (int r = 0; r < 6; r++) begin
      int n, passes;
      n = $urandom_range(1, DEPTH);
      passes = $urandom_range(1, 2);
      total = 0;
      for (int i = 0; i < n; i++) begin
        msg[i] = 2'($urandom);
        total += (ON_U[msg[i]] + OFF_U[msg[i]]) * UNIT_CNT;
      end
      load(n);
      play(n, passes, r[0], fd, ld);
      check("rand_done_cycle", ld, passes * (total + 1));
    end

    // asynchronous reset in the middle of the first dot
    set_sos(); load(11);
    @(negedge CLK);
    len = 5'd11; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("pre_rst_pin", pin_out, 1);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("async_rst_pin", pin_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check("after_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
